// File: rtl/id_ex_pkg.sv
// id_ex_pkg: control and payload types shared by the ID->EX boundary register.
package id_ex_pkg;
    localparam int ID_EX_DATA_W = 32;
    localparam int ID_EX_WA_W   = 4;
    localparam int ID_EX_ALUC_W = 3;

    typedef struct packed {
        logic                    RegWrite;
        logic                    MemtoReg;
        logic                    MemWrite;
        logic [ID_EX_ALUC_W-1:0] ALUControl;
        logic                    ALUSrc;
        logic                    FlagsWrite;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        ctrl_t                   ctrl;
        logic [ID_EX_WA_W-1:0]   wa3;
        logic [ID_EX_DATA_W-1:0] rd1;
        logic [ID_EX_DATA_W-1:0] rd2;
        logic [ID_EX_DATA_W-1:0] imm;
    } id_ex_payload_t;
endpackage

// File: rtl/id_ex_elastic_stage_pipe_skid_reg.sv
// pipe_skid_reg: valid/ready register on a packed payload with an optional skid slot.
module pipe_skid_reg #(
    parameter type T       = logic [7:0],
    parameter bit  SKID_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  T           in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output T           out_data,
    output logic [1:0] occ
);
    logic r_main_valid, r_rdy;
    logic w_skid_valid, w_in_xfer, w_drain, w_skid_next;
    T     r_main, w_skid_data;

    assign w_in_xfer   = in_valid & in_ready;
    assign w_drain     = ~r_main_valid | out_ready;
    assign w_skid_next = ~flush & ~w_drain & (w_skid_valid | w_in_xfer);
    // r_rdy is low throughout reset so in_ready stays low until the first edge after release
    assign in_ready    = SKID_EN ? r_rdy : r_rdy & w_drain;
    assign out_valid   = r_main_valid;
    assign out_data    = r_main;
    assign occ         = {w_skid_valid, r_main_valid & ~w_skid_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main       <= '0;
            r_rdy        <= 1'b0;
        end else begin
            r_rdy <= SKID_EN ? ~w_skid_next : 1'b1;
            if (flush)
                r_main_valid <= 1'b0;
            else if (w_drain) begin
                r_main_valid <= w_skid_valid | w_in_xfer;
                if (w_skid_valid)
                    r_main <= w_skid_data;
                else if (w_in_xfer)
                    r_main <= in_data;
            end
        end
    end

    if (SKID_EN) begin : g_skid
        logic r_skid_valid;
        T     r_skid;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_skid_valid <= 1'b0;
                r_skid       <= '0;
            end else begin
                r_skid_valid <= w_skid_next;
                if (~w_drain & w_in_xfer)
                    r_skid <= in_data;
            end
        end
        assign w_skid_valid = r_skid_valid;
        assign w_skid_data  = r_skid;
    end else begin : g_noskid
        assign w_skid_valid = 1'b0;
        assign w_skid_data  = '0;
    end
endmodule

// File: rtl/id_ex_elastic_stage.sv
// id_ex_elastic_stage: ID->EX pipeline register with handshake, flush and optional skid slot.
module id_ex_elastic_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int WA_W    = 4,
    parameter int ALUC_W  = 3,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  ctrl_t             in_ctrl,
    input  logic [WA_W-1:0]   in_wa3,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output ctrl_t             out_ctrl,
    output logic [WA_W-1:0]   out_wa3,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [1:0]        occ
);
    typedef struct packed {
        ctrl_t             ctrl;
        logic [WA_W-1:0]   wa3;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } payload_t;

    payload_t w_in, w_out;

    assign w_in = '{ctrl: in_ctrl, wa3: in_wa3, rd1: in_rd1, rd2: in_rd2, imm: in_imm};

    pipe_skid_reg #(.T(payload_t), .SKID_EN(SKID_EN)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out),
        .occ      (occ)
    );

    // Write-enables are masked so a bubble can never commit architectural state
    always_comb begin
        out_ctrl            = w_out.ctrl;
        out_ctrl.RegWrite   = w_out.ctrl.RegWrite & out_valid;
        out_ctrl.MemWrite   = w_out.ctrl.MemWrite & out_valid;
        out_ctrl.FlagsWrite = w_out.ctrl.FlagsWrite & out_valid;
        out_ctrl.ALUControl = w_out.ctrl.ALUControl[ALUC_W-1:0];
    end

    assign out_wa3 = w_out.wa3;
    assign out_rd1 = w_out.rd1;
    assign out_rd2 = w_out.rd2;
    assign out_imm = w_out.imm;
endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// tb_id_ex_elastic_stage: FIFO-model scoreboard for the skid build plus directed checks of the no-skid build.
module tb_id_ex_elastic_stage;
    import id_ex_pkg::*;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [3:0]  wa3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
    } ent_t;

    logic clk = 1'b0, rst = 1'b1;
    logic flush, in_valid, in_ready, out_valid, out_ready;
    ctrl_t in_ctrl, out_ctrl;
    logic [3:0] in_wa3, out_wa3;
    logic [31:0] in_rd1, in_rd2, in_imm, out_rd1, out_rd2, out_imm;
    logic [1:0] occ;

    logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    ctrl_t b_in_ctrl, b_out_ctrl;
    logic [3:0] b_in_wa3, b_out_wa3;
    logic [31:0] b_in_rd1, b_in_rd2, b_in_imm, b_out_rd1, b_out_rd2, b_out_imm;
    logic [1:0] b_occ;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;
    ent_t q[$];
    ent_t last;
    ctrl_t e_c;
    bit rdy_m;
    logic [31:0] rnd;

    always #5 clk = ~clk;

    id_ex_elastic_stage #(.SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_wa3(in_wa3), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_wa3(out_wa3),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .occ(occ)
    );

    id_ex_elastic_stage #(.SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_wa3(b_in_wa3), .in_rd1(b_in_rd1), .in_rd2(b_in_rd2), .in_imm(b_in_imm),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_wa3(b_out_wa3),
        .out_rd1(b_out_rd1), .out_rd2(b_out_rd2), .out_imm(b_out_imm), .occ(b_occ)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, bit r, bit f, logic [31:0] d);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_rd1    = d;
        rnd       = $urandom;
        in_ctrl   = rnd[CTRL_W-1:0];
        in_wa3    = rnd[11:8];
        in_rd2    = $urandom;
        in_imm    = $urandom;
    endtask

    // Reference model: the stage is a FIFO of depth 2; it accepts while fewer than 2 held
    always @(negedge clk) begin
        if (chk_en) begin
            chk("occ", 64'(occ), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() != 0) last = q[0];
            e_c = last.ctrl;
            if (q.size() == 0) begin
                e_c.RegWrite   = 1'b0;
                e_c.MemWrite   = 1'b0;
                e_c.FlagsWrite = 1'b0;
            end
            chk("out_ctrl", 64'(out_ctrl), 64'(e_c));
            chk("out_wa3", 64'(out_wa3), 64'(last.wa3));
            chk("out_rd1", 64'(out_rd1), 64'(last.rd1));
            chk("out_rd2", 64'(out_rd2), 64'(last.rd2));
            chk("out_imm", 64'(out_imm), 64'(last.imm));
            rdy_m = q.size() < 2;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && rdy_m) q.push_back('{in_ctrl, in_wa3, in_rd1, in_rd2, in_imm});
        end
    end

    initial begin
        drive(0, 0, 0, 0);
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = '0;
        b_in_wa3 = 4'h3; b_in_rd1 = 0; b_in_rd2 = 0; b_in_imm = 0;
        last = '0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_b_in_ready", 64'(b_in_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_in_ready_low", 64'(in_ready), 64'(0));
        cyc();
        chk("rel_in_ready", 64'(in_ready), 64'(1));
        chk_en = 1'b1;

        // streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 0, 32'(i));
            cyc();
            chk("t2_rd1", 64'(out_rd1), 64'(i));
            chk("t2_occ", 64'(occ), 64'(1));
        end
        drive(0, 1, 0, 0);
        repeat (2) cyc();

        // back-pressure fills the skid slot
        drive(1, 0, 0, 32'hA); cyc();
        drive(1, 0, 0, 32'hB); cyc();
        drive(0, 0, 0, 0); cyc();
        chk("t3_occ", 64'(occ), 64'(2));
        chk("t3_in_ready", 64'(in_ready), 64'(0));
        chk("t3_rd1", 64'(out_rd1), 64'hA);
        drive(0, 1, 0, 0); cyc();
        chk("t3_rd1_b", 64'(out_rd1), 64'hB);
        chk("t3_in_ready_b", 64'(in_ready), 64'(1));
        cyc();
        chk("t3_empty", 64'(occ), 64'(0));

        // flush with both slots full and an incoming entry
        drive(1, 0, 0, 32'h11); cyc();
        drive(1, 0, 0, 32'h12); cyc();
        drive(1, 0, 1, 32'hC); cyc();
        chk("t4_valid", 64'(out_valid), 64'(0));
        chk("t4_occ", 64'(occ), 64'(0));
        chk("t4_rd1", 64'(out_rd1), 64'h11);
        drive(0, 1, 0, 0); repeat (2) cyc();

        // bubble gating of MemWrite
        drive(1, 1, 0, 32'h55);
        in_ctrl.MemWrite = 1'b1;
        cyc();
        chk("t5_mw_on", 64'(out_ctrl.MemWrite), 64'(1));
        drive(0, 1, 0, 0); cyc();
        chk("t5_mw_off", 64'(out_ctrl.MemWrite), 64'(0));
        chk("t5_rd1", 64'(out_rd1), 64'h55);

        // asynchronous reset with two entries held
        drive(1, 0, 0, 32'h21); cyc();
        drive(1, 0, 0, 32'h22); cyc();
        drive(0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t1_valid", 64'(out_valid), 64'(0));
        chk("t1_occ", 64'(occ), 64'(0));
        chk("t1_ctrl", 64'(out_ctrl), 64'(0));
        chk("t1_in_ready", 64'(in_ready), 64'(0));
        chk("t1_rd1", 64'(out_rd1), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        last = '0;
        cyc();
        chk("t1_in_ready_rel", 64'(in_ready), 64'(1));
        chk_en = 1'b1;

        // randomized traffic against the FIFO model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom);
            cyc();
        end
        drive(0, 1, 0, 0);
        repeat (3) cyc();

        // single-entry build: combinational in_ready and pass-through
        b_in_valid = 1; b_in_rd1 = 1; b_out_ready = 0;
        cyc();
        chk("t6_valid", 64'(b_out_valid), 64'(1));
        chk("t6_in_ready_stall", 64'(b_in_ready), 64'(0));
        b_out_ready = 1;
        #1;
        chk("t6_in_ready_go", 64'(b_in_ready), 64'(1));
        for (int i = 2; i <= 9; i++) begin
            b_in_rd1 = 32'(i);
            cyc();
            chk("t6_rd1", 64'(b_out_rd1), 64'(i));
            chk("t6_occ", 64'(b_occ), 64'(1));
            chk("t6_in_ready", 64'(b_in_ready), 64'(1));
        end
        b_in_valid = 0;
        cyc();
        chk("t6_drain", 64'(b_out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
